// File: rtl/mem_arbiter_if.sv
// Request/response bundle joining the fetch and data requesters, the arbiter and the memory port.
// slave = arbiter side, master = requesters plus memory side.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  logic                  i_valid;
  logic                  i_ready;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_rvalid;
  logic [DATA_WIDTH-1:0] i_rdata;

  logic                  d_valid;
  logic                  d_ready;
  logic                  d_wen;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [MASK_WIDTH-1:0] d_wmask;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  mem_valid;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [MASK_WIDTH-1:0] mem_wmask;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  i_valid, i_addr,
    input  d_valid, d_wen, d_addr, d_wdata, d_wmask,
    input  mem_rvalid, mem_rdata,
    output i_ready, i_rvalid, i_rdata,
    output d_ready, d_rvalid, d_rdata,
    output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output i_valid, i_addr,
    output d_valid, d_wen, d_addr, d_wdata, d_wmask,
    output mem_rvalid, mem_rdata,
    input  i_ready, i_rvalid, i_rdata,
    input  d_ready, d_rvalid, d_rdata,
    input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port memory with a fixed one-cycle response.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin on conflicts; default is fixed priority D over I.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t r_state;
  owner_t r_owner;

  logic                  w_free;
  logic                  w_conflict;
  owner_t                w_winner;
  logic                  w_grant_i;
  logic                  w_grant_d;
  logic                  w_wen;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [MASK_WIDTH-1:0] w_wmask;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  owner_t r_rr_next;
`endif

  // The slot opens either when nothing is outstanding or as the outstanding response returns.
  assign w_free     = !rst && ((r_state == IDLE) || bus.mem_rvalid);
  assign w_conflict = bus.i_valid && bus.d_valid;

  always_comb begin
    w_winner = OWN_I;
    if (w_conflict) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      w_winner = r_rr_next;
`else
      w_winner = OWN_D;
`endif
    end else if (bus.d_valid) begin
      w_winner = OWN_D;
    end
  end

  assign w_grant_d = w_free && bus.d_valid && (w_winner == OWN_D);
  assign w_grant_i = w_free && bus.i_valid && (w_winner == OWN_I);

  always_comb begin
    w_wen   = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    w_wmask = '0;
    if (w_grant_d) begin
      w_wen   = bus.d_wen;
      w_addr  = bus.d_addr;
      w_wdata = bus.d_wdata;
      w_wmask = bus.d_wmask;
    end else if (w_grant_i) begin
      w_addr  = bus.i_addr;
    end
  end

  assign bus.i_ready   = w_grant_i;
  assign bus.d_ready   = w_grant_d;
  assign bus.mem_valid = w_grant_i || w_grant_d;
  assign bus.mem_wen   = w_wen;
  assign bus.mem_addr  = w_addr;
  assign bus.mem_wdata = w_wdata;
  assign bus.mem_wmask = w_wmask;

  // Responses route by the recorded owner; a stray mem_rvalid while IDLE reaches nobody.
  assign bus.i_rvalid = bus.mem_rvalid && (r_state == BUSY) && (r_owner == OWN_I);
  assign bus.d_rvalid = bus.mem_rvalid && (r_state == BUSY) && (r_owner == OWN_D);
  assign bus.i_rdata  = bus.mem_rdata;
  assign bus.d_rdata  = bus.mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= OWN_I;
    end else if (w_free) begin
      if (w_grant_i || w_grant_d) begin
        r_state <= BUSY;
        r_owner <= w_grant_d ? OWN_D : OWN_I;
      end else begin
        r_state <= IDLE;
      end
    end
  end

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // Only a contested grant moves the pointer; the loser is favoured next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_next <= OWN_D;
    end else if (w_free && w_conflict) begin
      r_rr_next <= (w_winner == OWN_D) ? OWN_I : OWN_D;
    end
  end
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single-port `memory` between the instruction-fetch path (read-only) and the data-access path (read/write). Sits between the core front/back ends and the memory block. Grants one access at a time, tracks the outstanding owner, and routes the one-cycle-later response back. Sustains one access per cycle when requests are back-to-back.

## Interface
- `ADDR_WIDTH`, 16, word address width; matches memory.
- `DATA_WIDTH`, 64, data width; `wmask` is `DATA_WIDTH/8` bits.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_valid`  in  1  fetch request.
- `i_ready`  out  1  fetch request accepted this cycle.
- `i_addr`  in  ADDR_WIDTH  fetch address.
- `i_rvalid`  out  1  fetch response valid.
- `i_rdata`  out  DATA_WIDTH  fetch response data.
- `d_valid`  in  1  data request.
- `d_ready`  out  1  data request accepted this cycle.
- `d_wen`  in  1  data write enable.
- `d_addr`  in  ADDR_WIDTH  data address.
- `d_wdata`  in  DATA_WIDTH  write data.
- `d_wmask`  in  DATA_WIDTH/8  byte write mask.
- `d_rvalid`  out  1  data response valid; also acknowledges writes.
- `d_rdata`  out  DATA_WIDTH  data response; for writes, pre-write contents.
- `mem_valid`  out  1  request to memory.
- `mem_wen`  out  1  write enable to memory.
- `mem_addr`  out  ADDR_WIDTH  address to memory.
- `mem_wdata`  out  DATA_WIDTH  write data to memory.
- `mem_wmask`  out  DATA_WIDTH/8  byte mask to memory.
- `mem_rvalid`  in  1  memory response valid, one cycle after `mem_valid`.
- `mem_rdata`  in  DATA_WIDTH  memory response data.

## Operation
- States: `IDLE` (nothing outstanding), `BUSY` (one access outstanding, owner register `I` or `D`).
- Slot free when state is `IDLE`, or `BUSY` with `mem_rvalid`=1.
- In a free slot with any `x_valid`: select winner, assert winner's `x_ready`, drive `mem_valid`=1 and winner's fields; go/stay `BUSY`, owner := winner.
- Free slot, no valid: go to `IDLE`, `mem_valid`=0.
- `BUSY` without `mem_rvalid`: no grants, both readys 0.
- Fetch grant drives `mem_wen`=0, `mem_wdata`=0, `mem_wmask`=0.
- Response: `x_rvalid` = `mem_rvalid` && state `BUSY` && owner==x; `i_rdata`=`d_rdata`=`mem_rdata` unconditionally.
- `mem_rvalid` in `IDLE` is ignored (no `x_rvalid`).
- Requesters hold request fields stable while `x_valid`=1 and `x_ready`=0; arbiter never buffers requests.

## Timing
- Outputs combinational from state, owner, `mem_rvalid` and requests; no registered outputs.
- While `rst`=1 and first cycle after: state `IDLE`, owner `I`, RR pointer `D`-first; all readys, `mem_valid`, `x_rvalid` 0 during reset.
- Grant at cycle T → response at T+1; new grant allowed at T+1 (back-to-back).
- Reset during `BUSY`: outstanding response dropped; a `mem_rvalid` arriving after reset is ignored.
- `ready` never asserted without matching `valid`; at most one ready per cycle.

## Configuration
- `MEM_ARBITER_ROUND_ROBIN_EN` defined: round-robin; on conflict the requester not granted last wins; pointer updates only on conflicting grants; reset pointer favours `D`.
- Undefined: fixed priority, `D` always beats `I`; no pointer register.

## Test plan
- Fetch only: `i_valid`=1 addr 0x10 continuously → `i_ready` every cycle, `i_rvalid` each cycle from T+1 with mem[0x10..] data.
- Data write 0xFF mask 0x01 to 0x20, then read 0x20 → write ack `d_rvalid` with old data, read returns low byte 0xFF.
- Conflict, macro undefined: both valid for 4 cycles → `d_ready` all 4, `i_ready` 0.
- Conflict, macro defined: both valid 4 cycles → grants D,I,D,I; responses routed to matching owner.
- Stray `mem_rvalid`=1 in `IDLE` → no `i_rvalid`/`d_rvalid`.
- Assert `rst` the cycle after a data grant → `d_rvalid` stays 0; first post-reset grant goes to `D` on conflict.
